// File: rtl/uc_pkg.sv
// Shared types and micro-word layout for the microsequenced control unit.
// The ctrl field keeps the bit order of the single-cycle control encoding.
package uc_pkg;

   typedef enum logic [1:0] {
      DISPATCH = 2'd0,
      EXEC     = 2'd1,
      INT      = 2'd2
   } uc_state_e;

   // ctrl[11:0] bit positions, MSB first: pcinc cjmp ret Wreg Sregin SBalu ENflag OPalu Wbus
   localparam int CTRL_W       = 12;
   localparam int C_PCINC      = 11;
   localparam int C_CJMP       = 10;
   localparam int C_RET        = 9;
   localparam int C_WREG       = 8;
   localparam int C_SREGIN_LSB = 6;
   localparam int SREGIN_W     = 2;
   localparam int C_SBALU      = 5;
   localparam int C_ENFLAG     = 4;
   localparam int C_OPALU_LSB  = 1;
   localparam int OPALU_W      = 3;
   localparam int C_WBUS       = 0;

   function automatic int uw_width(input int fsw, input int uaw);
      return CTRL_W + 1 + 1 + fsw + uaw;
   endfunction

   function automatic int end_bit(input int fsw, input int uaw);
      return fsw + uaw + 1;
   endfunction

   function automatic int ubr_bit(input int fsw, input int uaw);
      return fsw + uaw;
   endfunction

   function automatic int fsel_lsb(input int uaw);
      return uaw;
   endfunction

   localparam int DEF_FSW = 2;
   localparam int DEF_UAW = 6;
   localparam int DEF_UW  = uw_width(DEF_FSW, DEF_UAW);

endpackage

// File: rtl/uc_ustore.sv
// 1R1W RAM with synchronous write and read-first read; the read side is either
// registered (with enable and output clear) or combinational.
module uc_ustore #(
   parameter int AW      = 6,
   parameter int DW      = 22,
   parameter bit REG_OUT = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   // NOTE: the array has no reset; its contents are loaded through the write port and survive rst.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   generate
      if (REG_OUT) begin : g_reg
         always_ff @(posedge clk) begin
            if (rst)     rdata <= '0;
            else if (re) rdata <= mem[raddr];
         end
      end else begin : g_comb
         logic unused_ctl;
         assign unused_ctl = rst ^ re;
         assign rdata      = mem[raddr];
      end
   endgenerate

endmodule

// File: rtl/uc_seq.sv
// Microsequenced control unit: opcode dispatch into a writable micro-store,
// flag micro-branches and interrupt entry, driving the datapath control set.
module uc_seq
   import uc_pkg::*;
#(
   parameter int             OPW     = 5,
   parameter int             UAW     = 6,
   parameter int             NFLAG   = 4,
   parameter int             FSW     = 2,
   parameter logic [UAW-1:0] INT_VEC = 6'h3C,
   localparam int            UW      = uw_width(FSW, UAW)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [OPW-1:0]   OPCode,
   input  logic [FSW-1:0]   A,
   input  logic [NFLAG-1:0] FLAG,
   input  logic             IRvalid,
   input  logic             STALL,
   input  logic             interrupt,
   input  logic             UWE,
   input  logic [UAW-1:0]   UWADDR,
   input  logic [UW-1:0]    UWDATA,
   input  logic             DWE,
   input  logic [OPW-1:0]   DWADDR,
   input  logic [UAW-1:0]   DWDATA,
   output logic             IRld,
   output logic             iack,
   output logic             busy,
   output logic             PCpp,
   output logic             JMP,
   output logic             ret,
   output logic             Wreg,
   output logic [1:0]       Sregin,
   output logic             SBalu,
   output logic             ENflag,
   output logic [2:0]       OPalu,
   output logic             Wbus
);

   localparam int END_B  = end_bit(FSW, UAW);
   localparam int UBR_B  = ubr_bit(FSW, UAW);
   localparam int FSEL_L = fsel_lsb(UAW);

   uc_state_e        state, state_nxt;
   logic [UAW-1:0]   upc, upc_nxt, disp_upc;
   logic [UW-1:0]    uword;
   logic             pend, busy_q;

   logic [CTRL_W-1:0] ctrl;
   logic              w_end, w_ubr, jmp_c;
   logic [FSW-1:0]    w_fsel;
   logic [UAW-1:0]    w_tgt;

   assign ctrl   = uword[UW-1 -: CTRL_W];
   assign w_end  = uword[END_B];
   assign w_ubr  = uword[UBR_B];
   assign w_fsel = uword[FSEL_L +: FSW];
   assign w_tgt  = uword[UAW-1:0];

   // Addressed by the next upc so the word lands in its register on the same edge as upc.
   uc_ustore #(.AW(UAW), .DW(UW), .REG_OUT(1'b1)) u_ustore (
      .clk   (CLK),
      .rst   (RST),
      .we    (UWE),
      .waddr (UWADDR),
      .wdata (UWDATA),
      .re    (~STALL),
      .raddr (upc_nxt),
      .rdata (uword)
   );

   // Dispatch resolves in the IRld cycle, so the first micro-word drives controls one cycle later.
   uc_ustore #(.AW(OPW), .DW(UAW), .REG_OUT(1'b0)) u_dispatch (
      .clk   (CLK),
      .rst   (RST),
      .we    (DWE),
      .waddr (DWADDR),
      .wdata (DWDATA),
      .re    (1'b1),
      .raddr (OPCode),
      .rdata (disp_upc)
   );

   // NOTE: state lives in always_ff with <= only; all decode stays in always_comb with =.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= DISPATCH;
         upc    <= '0;
         pend   <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         upc    <= upc_nxt;
         pend   <= interrupt | (pend & ~iack);
         busy_q <= (state_nxt != DISPATCH);
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      upc_nxt   = upc;
      IRld      = 1'b0;
      iack      = 1'b0;
      if (!STALL) begin
         case (state)
            DISPATCH: begin
               if (pend) begin
                  iack      = 1'b1;
                  upc_nxt   = INT_VEC;
                  state_nxt = INT;
               end else if (IRvalid) begin
                  IRld      = 1'b1;
                  upc_nxt   = disp_upc;
                  state_nxt = EXEC;
               end
            end
            default: begin
               if (w_end)                      state_nxt = DISPATCH;
               else if (w_ubr && FLAG[w_fsel]) upc_nxt   = w_tgt;
               else                            upc_nxt   = upc + 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      jmp_c  = 1'b0;
      PCpp   = 1'b0;
      JMP    = 1'b0;
      ret    = 1'b0;
      Wreg   = 1'b0;
      Sregin = '0;
      SBalu  = 1'b0;
      ENflag = 1'b0;
      OPalu  = '0;
      Wbus   = 1'b0;
      if (state != DISPATCH) begin
         jmp_c  = ctrl[C_RET] | (ctrl[C_CJMP] & FLAG[A]);
         JMP    = jmp_c;
         PCpp   = ctrl[C_PCINC] & ~jmp_c;
         ret    = ctrl[C_RET];
         Wreg   = ctrl[C_WREG];
         Sregin = ctrl[C_SREGIN_LSB +: SREGIN_W];
         SBalu  = ctrl[C_SBALU];
         ENflag = ctrl[C_ENFLAG];
         OPalu  = ctrl[C_OPALU_LSB +: OPALU_W];
         Wbus   = ctrl[C_WBUS] | (state == INT);
      end
   end

   assign busy = busy_q;

endmodule
